// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of the shared combinational alu
module alu_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req_valid_0,
    input  logic               i_req_valid_1,
    input  logic [NB_DATA-1:0] i_data_a_0,
    input  logic [NB_DATA-1:0] i_data_a_1,
    input  logic [NB_DATA-1:0] i_data_b_0,
    input  logic [NB_DATA-1:0] i_data_b_1,
    input  logic [NB_OP-1:0]   i_op_0,
    input  logic [NB_OP-1:0]   i_op_1,
    output logic               o_req_ready_0,
    output logic               o_req_ready_1,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_res_valid_0,
    output logic               o_res_valid_1,
    input  logic               i_res_ready_0,
    input  logic               i_res_ready_1,
    output logic               o_busy,
    output logic               o_grant
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               grant_q, grant_d;
    logic               rv0_q, rv0_d;
    logic               rv1_q, rv1_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               any_req;
    logic               winner;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // requester 0 wins the first tie
            grant_q <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        rv0_d         = rv0_q;
        rv1_d         = rv1_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        res_d         = res_q;
        o_req_ready_0 = 1'b0;
        o_req_ready_1 = 1'b0;
        any_req       = i_req_valid_0 | i_req_valid_1;
        winner        = (i_req_valid_0 && i_req_valid_1) ? ~last_q : i_req_valid_1;

        case (state_q)
            IDLE: begin
                // ready is suppressed while reset is held so no handshake is seen
                if (any_req && i_reset) begin
                    o_req_ready_0 = ~winner;
                    o_req_ready_1 = winner;
                    grant_d       = winner;
                    last_d        = winner;
                    a_d           = winner ? i_data_a_1 : i_data_a_0;
                    b_d           = winner ? i_data_b_1 : i_data_b_0;
                    op_d          = winner ? i_op_1 : i_op_0;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                res_d   = i_alu_result;
                rv0_d   = ~grant_q;
                rv1_d   = grant_q;
                state_d = DONE;
            end
            DONE: begin
                if (grant_q ? i_res_ready_1 : i_res_ready_0) begin
                    rv0_d   = 1'b0;
                    rv1_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_alu_data_a  = a_q;
    assign o_alu_data_b  = b_q;
    assign o_alu_op      = op_q;
    assign o_result      = res_q;
    assign o_res_valid_0 = rv0_q;
    assign o_res_valid_1 = rv1_q;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural alu
module tb_alu_arbiter;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;

    typedef struct packed {
        logic             id;
        logic [NB_DATA-1:0] res;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic               v0, v1, rdy0, rdy1;
    logic [NB_DATA-1:0] a0, a1, b0, b1;
    logic [NB_OP-1:0]   op0, op1;
    logic [NB_DATA-1:0] alu_a, alu_b, alu_res, result;
    logic [NB_OP-1:0]   alu_op;
    logic               rv0, rv1, rr0, rr1, busy, grant;

    logic [NB_DATA-1:0] exp_0, exp_1;
    exp_t               sb[$];
    logic               grant_log[$];
    int                 acc_count = 0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            default: alu_res = '0;
        endcase
    end

    alu_arbiter #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .i_clock(clk), .i_reset(rstn),
        .i_req_valid_0(v0), .i_req_valid_1(v1),
        .i_data_a_0(a0), .i_data_a_1(a1),
        .i_data_b_0(b0), .i_data_b_1(b1),
        .i_op_0(op0), .i_op_1(op1),
        .o_req_ready_0(rdy0), .o_req_ready_1(rdy1),
        .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_res), .o_result(result),
        .o_res_valid_0(rv0), .o_res_valid_1(rv1),
        .i_res_ready_0(rr0), .i_res_ready_1(rr1),
        .o_busy(busy), .o_grant(grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // acceptance observer: pushes the hand-computed expectation of the accepted requester
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (v0 && rdy0) begin
                e = {1'b0, exp_0};
                sb.push_back(e);
                grant_log.push_back(1'b0);
                acc_count++;
            end
            if (v1 && rdy1) begin
                e = {1'b1, exp_1};
                sb.push_back(e);
                grant_log.push_back(1'b1);
                acc_count++;
            end
        end
    end

    // result monitor: pops on every result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rstn && ((rv0 && rr0) || (rv1 && rr1))) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("result_owner", 32'({rv1, rv0}), 32'(e.id ? 2'b10 : 2'b01));
                check("result_value", 32'(result), 32'(e.res));
                check("result_grant", 32'(grant), 32'(e.id));
            end
        end
    end

    task automatic wait_acc(input int target, input string name);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_count >= target) return;
        end
        check({name, "_accept_timeout"}, 32'(acc_count), 32'(target));
    endtask

    task automatic wait_rv(input logic which, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (which ? rv1 : rv0) return;
        end
        check({name, "_result_timeout"}, 32'(which ? rv1 : rv0), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rstn = 1'b0; v0 = 1'b1; v1 = 1'b1;
        a0 = 8'h11; b0 = 8'h22; op0 = OP_ADD; a1 = 8'h33; b1 = 8'h44; op1 = OP_ADD;
        rr0 = 1'b0; rr1 = 1'b0; exp_0 = '0; exp_1 = '0;

        // reset held two cycles with both requesters valid
        idle_cycles(2);
        @(negedge clk);
        check("rst_ready", 32'({rdy1, rdy0}), 32'd0);
        check("rst_res_valid", 32'({rv1, rv0}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0; rstn = 1'b1;
        idle_cycles(1);

        // contention: four back-to-back transactions, alternating grants from 0
        grant_log.delete();
        rr0 = 1'b1; rr1 = 1'b1;
        a0 = 8'h01; b0 = 8'h01; op0 = OP_ADD; exp_0 = 8'h02;
        a1 = 8'h02; b1 = 8'h02; op1 = OP_ADD; exp_1 = 8'h04;
        base = acc_count;
        v0 = 1'b1; v1 = 1'b1;
        wait_acc(base + 4, "contention");
        v0 = 1'b0; v1 = 1'b0;
        idle_cycles(4);
        check("contention_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > 0)
                check("contention_order", 32'(grant_log.pop_front()), 32'(i % 2));
        end

        // single op from requester 0
        a0 = 8'h05; b0 = 8'h03; op0 = OP_ADD; exp_0 = 8'h08; rr0 = 1'b1;
        v0 = 1'b1;
        @(negedge clk);
        check("single_ready0", 32'({rdy1, rdy0}), 32'b01);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        check("single_ready_exec", 32'({rdy1, rdy0}), 32'd0);
        check("single_alu", 32'({alu_a, alu_b, alu_op}), 32'({8'h05, 8'h03, OP_ADD}));
        check("single_exec_rv", 32'({rv1, rv0}), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_done_rv", 32'({rv1, rv0}), 32'b01);
        check("single_done_result", 32'(result), 32'h08);
        @(negedge clk);
        check("single_idle", 32'(busy), 32'd0);

        // backpressure on requester 1 with requester 0 pending
        rr0 = 1'b1; rr1 = 1'b0;
        a1 = 8'h09; b1 = 8'h04; op1 = OP_SUB; exp_1 = 8'h05;
        base = acc_count;
        v1 = 1'b1;
        wait_acc(base + 1, "bp");
        v1 = 1'b0;
        wait_rv(1'b1, "bp");
        a0 = 8'h07; b0 = 8'h06; op0 = OP_ADD; exp_0 = 8'h0d;
        v0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({result, rv1, rv0, rdy1, rdy0, busy}), 32'({8'h05, 5'b10001}));
        end
        @(posedge clk); #1;
        rr1 = 1'b1;
        @(negedge clk);
        check("bp_release_done", 32'({busy, rdy0}), 32'b10);
        @(negedge clk);
        check("bp_idle_ready0", 32'({busy, rdy0}), 32'b01);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        check("bp_req0_accepted", 32'({busy, grant, alu_a, alu_b}), 32'({2'b10, 8'h07, 8'h06}));
        idle_cycles(3);

        // wrong-consumer ready while requester 0 owns the result
        rr0 = 1'b0; rr1 = 1'b0;
        a0 = 8'h10; b0 = 8'h20; op0 = OP_ADD; exp_0 = 8'h30;
        base = acc_count;
        v0 = 1'b1;
        wait_acc(base + 1, "wrong");
        v0 = 1'b0;
        wait_rv(1'b0, "wrong");
        @(posedge clk); #1;
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        @(negedge clk);
        check("wrong_hold", 32'({busy, rv1, rv0, result}), 32'({3'b101, 8'h30}));
        rr0 = 1'b1;
        idle_cycles(2);
        @(negedge clk);
        check("wrong_released", 32'({busy, rv0}), 32'd0);

        // reset during EXEC abandons the transaction
        rr0 = 1'b1; rr1 = 1'b1;
        a0 = 8'h03; b0 = 8'h04; op0 = OP_ADD; exp_0 = 8'h07;
        a1 = 8'h0a; b1 = 8'h01; op1 = OP_SUB; exp_1 = 8'h09;
        v0 = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0; v0 = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_quiet", 32'({busy, rv1, rv0, result}), 32'd0);
        end
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("midrst_tie_winner", 32'({rdy1, rdy0}), 32'b01);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        idle_cycles(4);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares the single combinational `alu` between independent command sources, for example the button/switch loader and a future serial command port. It accepts an operand/opcode triple from one requester per transaction and registers it onto the ALU inputs. It captures the ALU result one cycle later and returns it to the granted requester over a valid/ready handshake. It sits between the requesters and `alu` inside the top level.

## Interface
- NB_DATA, 8, operand and result width
- NB_OP, 6, opcode width
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  reset, synchronous and active-low (0 = reset)
- i_req_valid_0 / i_req_valid_1  in  1  requester N has a command
- i_data_a_0 / i_data_a_1  in  NB_DATA  operand A of requester N
- i_data_b_0 / i_data_b_1  in  NB_DATA  operand B of requester N
- i_op_0 / i_op_1  in  NB_OP  opcode of requester N
- o_req_ready_0 / o_req_ready_1  out  1  command from requester N accepted this cycle
- o_alu_data_a  out  NB_DATA  registered operand A to alu
- o_alu_data_b  out  NB_DATA  registered operand B to alu
- o_alu_op  out  NB_OP  registered opcode to alu
- i_alu_result  in  NB_DATA  combinational result from alu
- o_result  out  NB_DATA  captured result, shared by both requesters
- o_res_valid_0 / o_res_valid_1  out  1  o_result belongs to requester N and is valid
- i_res_ready_0 / i_res_ready_1  in  1  requester N consumes the result
- o_busy  out  1  high in any state other than IDLE
- o_grant  out  1  index of the requester last granted

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Winner selection: if exactly one i_req_valid_N is high, N wins. If both are high, the requester not equal to the last grant wins.
  - o_req_ready_N is driven combinationally high for the winner only.
  - Acceptance is the edge where valid and ready are both high. On that edge: latch the winner's a/b/op into the o_alu_* registers, set o_grant to N, and go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: one cycle. The alu sees stable registered operands. On the closing edge, capture i_alu_result into o_result and go to DONE.
- DONE:
  - o_res_valid_<o_grant> is high; the other o_res_valid is low.
  - On the edge with i_res_ready_<o_grant> high, clear o_res_valid and go to IDLE.
  - i_res_ready of the non-granted requester is ignored.
  - o_result and o_alu_* hold while waiting, with no timeout.
- o_req_ready_0 and o_req_ready_1 are low in EXEC and DONE. New requests wait and must hold valid and their data until accepted.
- o_alu_* hold their last values outside an acceptance edge.
- No arithmetic is performed here. Widths pass through unchanged.
- Reset (i_reset == 0 at an edge):
  - State goes to IDLE; all outputs are 0.
  - The internal last-grant pointer resets to 1, so requester 0 wins the first tie.
  - A reset during EXEC or DONE abandons the transaction; no result is delivered.

## Timing
- Accept at edge T0. o_alu_* are valid after T0. o_result and o_res_valid are valid after T0+1, so result latency is 2 cycles from acceptance.
- Minimum spacing between acceptances is 3 cycles, reached when i_res_ready is held high.
- A request asserted in DONE can be accepted at the first IDLE edge after the result handshake.
- o_req_ready depends combinationally on i_req_valid and the state. Every other output is registered.
- Fairness: with both requesters continuously valid and ready, grants alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- Reset: hold i_reset=0 for 2 cycles with both valid high. Expect every ready, res_valid, o_result and o_busy = 0, and o_alu_* = 0.
- Single op: requester 0 sends a=8'h05, b=8'h03, op=ADD code with i_res_ready_0=1. Expect ready_0 high for one cycle and o_alu_* = 05/03/op one cycle later. Expect o_result=8'h08 with res_valid_0 high exactly 2 cycles after acceptance, and res_valid_1 never high.
- Contention: both requesters valid continuously for 4 transactions (req0 a=1,b=1; req1 a=2,b=2; op=ADD). Expect grant order 0,1,0,1 and results 02,04,02,04 on the matching res_valid line.
- Backpressure: hold i_res_ready_1=0 for 5 cycles after a req1 result appears. Expect o_result and res_valid_1 stable, both readies low, and req0 pending with no grant. Then raise ready_1: expect IDLE next and req0 accepted on the following edge.
- Wrong-consumer ready: in DONE for req0, pulse i_res_ready_1. Expect no state change and res_valid_0 still high.
- Mid-op reset: assert i_reset=0 during EXEC. Expect IDLE, no res_valid pulse, and after release requester 0 winning a simultaneous request.
